// File: rtl/aes_block_feeder_pkg.sv
// Shared constants and FSM encoding for the AES block feeder.
// Latency: none (types and constants only).
// Backpressure: n/a; the S_ERR state exists only when AES_FEEDER_TIMEOUT_EN is defined.
package aes_feed_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_W     = 128;
    localparam int CNT_W       = 5;

    typedef enum logic [2:0] {
        S_FILL  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
`ifdef AES_FEEDER_TIMEOUT_EN
        S_ERR   = 3'd4,
`endif
        S_OUT   = 3'd3
    } feed_state_t;

    // A block made entirely of the pad byte, the state of an empty packer.
    function automatic logic [BLOCK_W-1:0] pad_block(input logic [7:0] pad);
        return {BLOCK_BYTES{pad}};
    endfunction

endpackage

// File: rtl/aes_block_feeder_if.sv
// Byte-in / ciphertext-out stream bundle of the AES block feeder.
// Latency: none (wiring only).
// Backpressure: in_valid/in_ready on the byte side, ct_valid/ct_ready on the ciphertext side.
interface aes_block_feeder_if;
    import aes_feed_pkg::*;

    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               in_flush;
    logic               ct_valid;
    logic [BLOCK_W-1:0] ct_data;
    logic [CNT_W-1:0]   ct_bytes;
    logic               ct_last;
    logic               ct_ready;

    // The feeder itself.
    modport slave (
        input  in_valid, in_data, in_flush, ct_ready,
        output in_ready, ct_valid, ct_data, ct_bytes, ct_last
    );

    // The byte source and ciphertext sink around the feeder.
    modport master (
        output in_valid, in_data, in_flush, ct_ready,
        input  in_ready, ct_valid, ct_data, ct_bytes, ct_last
    );
endinterface

// File: rtl/aes_block_feeder_byte_packer.sv
// aes_byte_packer: shifts bytes into a 128-bit block, first byte ends up most significant.
// Latency: block and count update on the edge that accepts the byte.
// Backpressure: shifting is ignored once full; reload restores an all-pad empty block.
module aes_byte_packer
    import aes_feed_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               shift_en,
    input  logic [7:0]         in_byte,
    input  logic               reload,
    output logic [BLOCK_W-1:0] blk,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    assign full  = (count == CNT_W'(BLOCK_BYTES));
    assign empty = (count == '0);

    // Shift register and byte count; a partial block stays right-aligned with pad above.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blk   <= pad_block(PAD_BYTE);
            count <= '0;
        end else if (reload) begin
            blk   <= pad_block(PAD_BYTE);
            count <= '0;
        end else if (shift_en && !full) begin
            blk   <= {blk[BLOCK_W-9:0], in_byte};
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/aes_block_feeder.sv
// aes_block_feeder: packs bytes into 128-bit blocks, runs one encryption per block, emits ciphertext.
// Latency: aes_encrypt 1 cycle after the sealing byte/flush; ct_valid 1 cycle after aes_done is seen.
// Backpressure: in_ready low from seal until ct_valid&ct_ready; watchdog under `define AES_FEEDER_TIMEOUT_EN.
module aes_block_feeder
    import aes_feed_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [7:0] PAD_BYTE       = 8'h00
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [BLOCK_W-1:0] key,
    aes_block_feeder_if.slave  io,
    output logic [BLOCK_W-1:0] aes_plain_text,
    output logic [BLOCK_W-1:0] aes_key,
    output logic               aes_encrypt,
    input  logic               aes_done,
    input  logic [BLOCK_W-1:0] aes_dout,
    output logic               err
);

    feed_state_t        state, state_nxt;
    logic               accept, seal, seal_last, reload, capture;
    logic               first_wait, last_q, full, empty, ct_vld;
    logic [BLOCK_W-1:0] blk, pt_q, key_q, ct_q;
    logic [CNT_W-1:0]   count;

    aes_byte_packer #(.PAD_BYTE(PAD_BYTE)) u_packer (
        .clock    (clock),
        .reset_n  (reset_n),
        .shift_en (accept),
        .in_byte  (io.in_data),
        .reload   (reload),
        .blk      (blk),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

`ifdef AES_FEEDER_TIMEOUT_EN
    logic [15:0] wd_cnt;

    // Watchdog: counts cycles spent in WAIT, cleared while the start pulse is out.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                wd_cnt <= '0;
        else if (state == S_START)   wd_cnt <= '0;
        else if (state == S_WAIT)    wd_cnt <= wd_cnt + 1'b1;
    end

    assign err = (state == S_ERR);
`else
    assign err = 1'b0;
`endif

    // Next state plus the strobes that steer the packer and the latches.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        seal      = 1'b0;
        seal_last = 1'b0;
        reload    = 1'b0;
        capture   = 1'b0;
        case (state)
            S_FILL: begin
                accept = io.in_valid && !full;
                // A byte arriving with flush is packed first, so it counts toward the seal.
                if (accept && count == CNT_W'(BLOCK_BYTES - 1)) begin
                    seal      = 1'b1;
                    seal_last = io.in_flush;
                end else if (io.in_flush && (accept || !empty)) begin
                    seal      = 1'b1;
                    seal_last = 1'b1;
                end
                if (seal) state_nxt = S_START;
            end
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                // done may still be high from the previous block on the first WAIT cycle.
                if (aes_done && !first_wait) begin
                    capture   = 1'b1;
                    state_nxt = S_OUT;
                end
`ifdef AES_FEEDER_TIMEOUT_EN
                else if (wd_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt = S_ERR;
                end
`endif
            end
            S_OUT: begin
                if (io.ct_ready) begin
                    reload    = 1'b1;
                    state_nxt = S_FILL;
                end
            end
`ifdef AES_FEEDER_TIMEOUT_EN
            S_ERR: state_nxt = S_ERR;
`endif
            default: state_nxt = S_FILL;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_FILL;
        else          state <= state_nxt;
    end

    // Key and last flag at seal, plaintext during START, ciphertext when done is accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key_q      <= '0;
            pt_q       <= '0;
            ct_q       <= '0;
            last_q     <= 1'b0;
            first_wait <= 1'b0;
        end else begin
            first_wait <= (state == S_START);
            if (seal) begin
                key_q  <= key;
                last_q <= seal_last;
            end
            if (state == S_START) pt_q <= blk;
            if (capture)          ct_q <= aes_dout;
        end
    end

    assign ct_vld         = (state == S_OUT);
    assign io.in_ready    = (state == S_FILL) && !full;
    assign io.ct_valid    = ct_vld;
    assign io.ct_data     = ct_q;
    assign io.ct_bytes    = ct_vld ? count : '0;
    assign io.ct_last     = ct_vld && last_q;
    assign aes_encrypt    = (state == S_START);
    assign aes_plain_text = (state == S_START) ? blk : pt_q;
    assign aes_key        = key_q;

endmodule

// File: tb/tb_aes_block_feeder.sv
// Self-checking bench for aes_block_feeder with a behavioural encryptor stand-in.
// Latency: checks encrypt one cycle after seal and ct_valid one cycle after done is usable.
// Backpressure: exercises ct_ready stalls, idle ct_ready, flush corner cases, reset and timeout.
module tb_aes_block_feeder;
    import aes_feed_pkg::*;

    localparam int         TO  = 8;
    localparam logic [7:0] PAD = 8'h00;
    typedef logic [7:0] bq_t[$];

    logic         clock, reset_n;
    logic [127:0] key, aes_plain_text, aes_key, aes_dout;
    logic         aes_encrypt, aes_done, err;

    aes_block_feeder_if bus();

    aes_block_feeder #(.TIMEOUT_CYCLES(TO), .PAD_BYTE(PAD)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .key            (key),
        .io             (bus),
        .aes_plain_text (aes_plain_text),
        .aes_key        (aes_key),
        .aes_encrypt    (aes_encrypt),
        .aes_done       (aes_done),
        .aes_dout       (aes_dout),
        .err            (err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_enc    = 0;
    int emu_lat  = 3;
    int emu_j    = -1;
    bit emu_stale = 0;
    bit emu_stuck = 0;
    logic [127:0] emu_pt, emu_key;

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    function automatic logic [127:0] cipher_model(input logic [127:0] p, input logic [127:0] k);
        return p ^ {k[63:0], k[127:64]} ^ {4{32'hC3A5_5A3C}};
    endfunction

    // Encryptor stand-in: done is a level that stays high until the next start.
    initial begin
        aes_done = 0;
        aes_dout = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                emu_j    = -1;
                aes_done = 0;
            end else if (aes_encrypt === 1'b1) begin
                n_enc++;
                emu_pt  = aes_plain_text;
                emu_key = aes_key;
                emu_j   = 0;
                if (!emu_stale) aes_done = 0;
            end else if (emu_j >= 0) begin
                emu_j++;
                if (emu_stale && emu_j == 2) aes_done = 0;
                if (emu_j == emu_lat && !emu_stuck) begin
                    aes_done = 1;
                    aes_dout = cipher_model(emu_pt, emu_key);
                    emu_j    = -1;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic reset_pulse();
        reset_n = 0;
        tick();
        reset_n = 1;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit fl, input int gap);
        int t = 0;
        repeat (gap) tick();
        bus.in_valid = 1;
        bus.in_data  = b;
        bus.in_flush = fl;
        while (bus.in_ready !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        if (t == 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_wait: in_ready=%b after 20 cycles, required 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 0;
        bus.in_flush = 0;
    endtask

    // mode 0: full block, no flush; 1: flush with last byte; 2: flush on its own cycle.
    task automatic run_block(input string name, input bq_t data, input int mode, input int stall,
                             input bit stale, input logic [127:0] k_seal);
        int n, enc0, t, bad;
        logic [127:0] exp_pt, exp_ct;
        n = data.size();
        exp_pt = {16{PAD}};
        for (int i = 0; i < n; i++) exp_pt[8*(n-1-i) +: 8] = data[i];
        exp_ct    = cipher_model(exp_pt, k_seal);
        key       = k_seal;
        emu_lat   = $urandom_range(3, 6);
        emu_stale = stale;
        enc0      = n_enc;
        for (int i = 0; i < n; i++) begin
            bus.ct_ready = (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            send_byte(data[i], (mode == 1) && (i == n - 1), $urandom_range(0, 2));
        end
        if (mode == 2) begin
            bus.in_flush = 1;
            tick();
            bus.in_flush = 0;
        end
        n_checks++;
        if (aes_encrypt !== 1'b1) begin
            n_fail++; $display("FAIL %s encrypt_pulse: got %b required 1", name, aes_encrypt);
        end
        n_checks++;
        if (aes_plain_text !== exp_pt) begin
            n_fail++; $display("FAIL %s plain_text: got %h required %h", name, aes_plain_text, exp_pt);
        end
        n_checks++;
        if (aes_key !== k_seal) begin
            n_fail++; $display("FAIL %s key: got %h required %h", name, aes_key, k_seal);
        end
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL %s in_ready_start: got %b required 0", name, bus.in_ready);
        end
        key = ~k_seal;
        t = 0;
        while (bus.ct_valid !== 1'b1 && t < 40) begin
            tick();
            t++;
        end
        n_checks++;
        if (t != emu_lat + 1) begin
            n_fail++; $display("FAIL %s ct_latency: got %0d cycles required %0d", name, t, emu_lat + 1);
        end
        n_checks++;
        if (bus.ct_data !== exp_ct) begin
            n_fail++; $display("FAIL %s ct_data: got %h required %h", name, bus.ct_data, exp_ct);
        end
        n_checks++;
        if (bus.ct_bytes !== 5'(n) || bus.ct_last !== (mode != 0)) begin
            n_fail++;
            $display("FAIL %s ct_bytes_last: got %0d/%b required %0d/%b", name, bus.ct_bytes, bus.ct_last, n, mode != 0);
        end
        bad = 0;
        repeat (stall) begin
            tick();
            if (bus.ct_valid !== 1'b1 || bus.ct_data !== exp_ct || bus.in_ready !== 1'b0 || aes_encrypt !== 1'b0)
                bad++;
        end
        if (stall > 0) begin
            n_checks++;
            if (bad != 0) begin
                n_fail++; $display("FAIL %s stall_stable: got %0d unstable cycles required 0", name, bad);
            end
        end
        bus.ct_ready = 1;
        tick();
        bus.ct_ready = 0;
        n_checks++;
        if (bus.ct_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s after_handshake: got valid=%b ready=%b required 0/1", name, bus.ct_valid, bus.in_ready);
        end
        n_checks++;
        if (n_enc != enc0 + 1) begin
            n_fail++; $display("FAIL %s encrypt_count: got %0d required %0d", name, n_enc - enc0, 1);
        end
        emu_stale = 0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if ({bus.in_ready, aes_encrypt, bus.ct_valid, bus.ct_last, err, bus.ct_bytes} !== {5'b10000, 5'd0}) begin
            n_fail++;
            $display("FAIL %s ctrl: got rdy=%b enc=%b vld=%b last=%b err=%b bytes=%0d required 1/0/0/0/0/0", name,
                     bus.in_ready, aes_encrypt, bus.ct_valid, bus.ct_last, err, bus.ct_bytes);
        end
        n_checks++;
        if ({aes_plain_text, aes_key, bus.ct_data} !== '0) begin
            n_fail++; $display("FAIL %s data: got pt=%h key=%h ct=%h required 0", name, aes_plain_text, aes_key, bus.ct_data);
        end
    endtask

    task automatic test_reset();
        reset_n = 0;
        key = '0;
        bus.in_valid = 0; bus.in_data = '0; bus.in_flush = 0; bus.ct_ready = 0;
        repeat (2) tick();
        check_reset_outputs("reset");
        reset_n = 1;
        tick();
    endtask

    task automatic test_full_block();
        bq_t q;
        for (int i = 0; i < 16; i++) q.push_back(8'(i));
        run_block("full_block", q, 0, 0, 0, rand128());
    endtask

    task automatic test_partial_flush();
        bq_t q;
        q.push_back(8'h32);
        q.push_back(8'h32);
        run_block("partial_flush", q, 2, 0, 0, 128'h00112233445566778899AABBCCDDEEFF);
    endtask

    task automatic test_ready_stall();
        bq_t q;
        for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
        run_block("ready_stall", q, 0, 20, 0, rand128());
    endtask

    task automatic test_flush_empty();
        int enc0 = n_enc;
        bus.in_flush = 1;
        tick();
        bus.in_flush = 0;
        repeat (4) tick();
        n_checks++;
        if (n_enc != enc0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_empty: got pulses=%0d ready=%b required 0/1", n_enc - enc0, bus.in_ready);
        end
    endtask

    task automatic test_flush_with_byte();
        bq_t q;
        for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
        run_block("flush_with_byte", q, 1, 0, 0, rand128());
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
        run_block("flush_16th", q, 1, 0, 0, rand128());
    endtask

    task automatic test_stale_done();
        bq_t q;
        for (int i = 0; i < 7; i++) q.push_back(8'($urandom));
        run_block("stale_done", q, 1, 0, 1, rand128());
    endtask

    task automatic test_random();
        for (int b = 0; b < 12; b++) begin
            bq_t q;
            int n, mode;
            n = $urandom_range(1, 16);
            mode = (n == 16) ? $urandom_range(0, 1) : $urandom_range(1, 2);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            run_block($sformatf("random%0d", b), q, mode, $urandom_range(0, 3), 1'($urandom_range(0, 1)), rand128());
        end
    endtask

    task automatic test_timeout();
        emu_stuck = 1;
        key = rand128();
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), 0, 0);
`ifdef AES_FEEDER_TIMEOUT_EN
        repeat (TO) tick();
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_early: got err=%b after %0d wait cycles required 0", err, TO);
        end
        tick();
        n_checks++;
        if ({err, bus.in_ready, bus.ct_valid, aes_encrypt} !== 4'b1000) begin
            n_fail++; $display("FAIL timeout_err: got err/rdy/vld/enc=%b%b%b%b required 1000", err, bus.in_ready, bus.ct_valid, aes_encrypt);
        end
        repeat (5) tick();
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL timeout_sticky: got err=%b required 1", err);
        end
`else
        repeat (TO + 6) tick();
        n_checks++;
        if ({err, bus.in_ready, bus.ct_valid} !== 3'b000) begin
            n_fail++; $display("FAIL wait_forever: got err/rdy/vld=%b%b%b required 000", err, bus.in_ready, bus.ct_valid);
        end
`endif
        reset_pulse();
        emu_stuck = 0;
        check_reset_outputs("after_timeout_reset");
    endtask

    task automatic test_reset_mid_wait();
        emu_stuck = 1;
        key = rand128();
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), 0, 0);
        repeat (3) tick();
        n_checks++;
        if (bus.ct_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_wait: got vld=%b rdy=%b required 0/0", bus.ct_valid, bus.in_ready);
        end
        reset_n = 0;
        #1;
        check_reset_outputs("reset_mid_wait");
        tick();
        reset_n = 1;
        emu_stuck = 0;
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_reset: got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_discard();
        bq_t q;
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0, 0);
        reset_pulse();
        q.push_back(8'h11);
        q.push_back(8'h22);
        run_block("discard", q, 2, 0, 0, rand128());
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_partial_flush();
        test_ready_stall();
        test_flush_empty();
        test_flush_with_byte();
        test_stale_done();
        test_random();
        test_timeout();
        test_reset_mid_wait();
        test_discard();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
